// File: rtl/pipeline_stage_skid.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer, synchronous
// NOP-inserting flush and a saturating back-pressure counter.
module pipeline_stage_skid #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0,
   parameter int               CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   input  logic             cnt_clr,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] w_main_nxt;
   logic [WIDTH-1:0] w_skid_nxt;
   logic             r_out_valid;
   logic             r_in_ready;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_accept;
   logic             w_drain;
   logic             w_stall;

   assign w_accept = in_valid & r_in_ready;
   assign w_drain  = r_out_valid & out_ready;
   assign w_stall  = r_out_valid & ~out_ready;

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   // NOTE: every combinational output gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         unique case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
            ST_ONE: begin
               if (w_accept && !w_drain)      w_state_nxt = ST_FULL;
               else if (!w_accept && w_drain) w_state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (w_drain) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Datapath steering: the main register always holds the oldest payload.
   always_comb begin
      w_main_nxt = r_main;
      w_skid_nxt = r_skid;
      if (flush) begin
         w_main_nxt = NOP_VALUE;
         w_skid_nxt = NOP_VALUE;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (w_accept) w_main_nxt = in_data;
            end
            ST_ONE: begin
               if (w_accept && w_drain)       w_main_nxt = in_data;
               else if (w_accept)             w_skid_nxt = in_data;
               else if (w_drain)              w_main_nxt = NOP_VALUE;
            end
            ST_FULL: begin
               if (w_drain) begin
                  w_main_nxt = r_skid;
                  w_skid_nxt = NOP_VALUE;
               end
            end
            default: begin
               w_main_nxt = NOP_VALUE;
               w_skid_nxt = NOP_VALUE;
            end
         endcase
      end
   end

   // Registered outputs: in_ready is a flop, never a function of out_ready.
   // NOTE: the payload registers are reset because out_data must read NOP_VALUE
   // while out_valid is low, including straight out of reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_main      <= NOP_VALUE;
         r_skid      <= NOP_VALUE;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         r_main      <= w_main_nxt;
         r_skid      <= w_skid_nxt;
         r_out_valid <= (w_state_nxt != ST_EMPTY);
         r_in_ready  <= (w_state_nxt != ST_FULL);
      end
   end

   // Stall counter: clear wins over increment, saturates at all-ones.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_stall_cnt <= '0;
      end else if (cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_main;
   assign occupancy = r_state;
   assign stall_cnt = r_stall_cnt;

endmodule
